// File: rtl/pu_spi_tx_buffer.sv
// pu_spi_tx_buffer
// Transmit-side word buffer for the SPI processor unit. The processor side
// writes words in; the SPI shifter pulls one word per rising edge of `ready`
// and gets them on a registered `data_out` in FIFO order.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous active-high reset
//   wr         write strobe, one word stored per high cycle
//   data_in    word to store when wr = 1
//   ready      shifter request (level); one word consumed per 0->1 transition
//   data_out   registered word presented to the shifter
//   empty      no words stored
//   full       BUF_SIZE words stored
//   underflow  sticky: request seen while empty
//   overflow   sticky: write seen while full
module pu_spi_tx_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_SIZE   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  underflow,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(BUF_SIZE);
  localparam int CNT_W = $clog2(BUF_SIZE + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_SIZE);

  logic [DATA_WIDTH-1:0] r_mem [BUF_SIZE];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ready_q;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_underflow;
  logic                  r_overflow;

  logic                  w_req;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;

  // Read and write are both judged against the pre-edge count, so a
  // simultaneous write never rescues an empty read nor a full write.
  always_comb begin
    w_req        = ready & ~r_ready_q;
    w_empty      = (r_count == '0);
    w_full       = (r_count == CNT_FULL);
    w_rd_ok      = w_req & ~w_empty;
    w_wr_ok      = wr & ~w_full;
    w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
    w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
  end

  // Storage has no reset; its contents are don't-care after rst.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ready_q   <= 1'b0;
      r_data_out  <= '0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_ready_q <= ready;

      if (w_req) begin
        if (w_empty) begin
          r_data_out  <= '0;
          r_underflow <= 1'b1;
        end else begin
          r_data_out <= r_mem[r_rd_ptr];
          r_rd_ptr   <= w_rd_ptr_nxt;
        end
      end

      if (wr) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_wr_ptr <= w_wr_ptr_nxt;
        end
      end

      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    data_out  = r_data_out;
    empty     = w_empty;
    full      = w_full;
    underflow = r_underflow;
    overflow  = r_overflow;
  end

endmodule

// File: doc/pu_spi_tx_buffer.md
Name: pu_spi_tx_buffer

Overview:
- Transmit-side word buffer for the SPI processor unit, the counterpart of the receive buffer. The processor side loads up to BUF_SIZE words. The SPI shifter requests one word per transfer by raising `ready`.
- Each request presents the next stored word on `data_out` in FIFO order, for the shifter to serialise.
- Provides `empty`/`full` status and sticky `underflow`/`overflow` error flags for the control logic.

Parameters:
- DATA_WIDTH, 8, width of one stored word.
- BUF_SIZE, 6, number of word slots; any integer >= 2, not necessarily a power of two.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr  input  1  write strobe; one word is stored per cycle in which it is high.
- data_in  input  DATA_WIDTH  word to store when `wr` = 1.
- ready  input  1  request from the SPI shifter; level signal, may be held high for several cycles.
- data_out  output  DATA_WIDTH  registered word currently presented to the shifter.
- empty  output  1  high when no words are stored.
- full  output  1  high when BUF_SIZE words are stored.
- underflow  output  1  sticky; a request arrived while the buffer was empty.
- overflow  output  1  sticky; a write arrived while the buffer was full.

Behaviour:
- Storage and pointers:
  - Storage: BUF_SIZE x DATA_WIDTH array.
  - Pointers `wr_ptr` and `rd_ptr` are each $clog2(BUF_SIZE) bits wide.
  - `count` is $clog2(BUF_SIZE+1) bits wide.
  - Each pointer wraps from BUF_SIZE-1 to 0.
- Reset, asynchronous while `rst` = 1:
  - Pointers, `count`, `data_out`, `underflow`, `overflow` and `ready_q` are all 0.
  - `empty` = 1, `full` = 0.
  - Array contents are don't-care.
  - Reset asserted mid-operation discards every stored word immediately.
- Request edge detect:
  - `ready_q` is `ready` registered.
  - `req` = `ready` & ~`ready_q`.
  - Exactly one word is consumed per low-to-high transition of `ready`, however long `ready` stays high.
- Read (`req` = 1):
  - If `count` > 0: at this clock edge, `data_out` <= mem[`rd_ptr`] and `rd_ptr` advances. The new word is visible one cycle after `ready` rises.
  - If `count` = 0: `data_out` <= 0, `underflow` <= 1, pointers unchanged.
- Write (`wr` = 1):
  - If `count` < BUF_SIZE: mem[`wr_ptr`] <= `data_in` and `wr_ptr` advances.
  - If `count` = BUF_SIZE: the write is dropped and `overflow` <= 1.
- Simultaneous `wr` and `req`:
  - The read and the write are each evaluated against `count` before the edge.
  - Not empty and not full: both happen and `count` is unchanged.
  - Empty: the read underflows and the write is stored, so `count` becomes 1. No bypass of the incoming word to `data_out`.
  - Full: the read succeeds and the write is dropped with `overflow` set, so `count` becomes BUF_SIZE-1.
- Status outputs:
  - `empty` = (`count` == 0) and `full` = (`count` == BUF_SIZE), both decoded combinationally from registered `count`.
  - `underflow` and `overflow` clear only on `rst`.
- Holding: `data_out` holds its value between requests.
- Target size: roughly 120–200 lines of RTL; no other state.

Test Plan:
- Reset: assert `rst` mid-cycle -> outputs drop immediately to `data_out` = 0, `empty` = 1, `full` = 0, both error flags 0.
- Basic FIFO order:
  - Write 2, 3, 4 on consecutive cycles -> `count` = 3.
  - Pulse `ready` high for 2 cycles, three times with 3 low cycles between -> `data_out` = 2, 3, 4, each one cycle after the `ready` rise.
  - Afterwards `empty` = 1.
- Held request: write 7, 8; hold `ready` high for 5 cycles -> only 7 is consumed, `count` = 1, `data_out` stays 7.
- Full, wrap and overflow:
  - Write 1..6 -> `full` = 1.
  - Write 9 -> dropped, `overflow` = 1.
  - Read six times -> 1..6.
  - Write 10, 11 and read -> 10, 11 across the pointer wrap.
- Underflow: with the buffer empty, raise `ready` -> `data_out` = 0, `underflow` = 1 and stays 1 after later successful reads.
- Simultaneous events:
  - Holding words 5 and 6, `wr` = 1 with `data_in` = 12 on the same cycle as `req` -> `data_out` = 5, `count` stays 2; subsequent reads give 6, 12.
  - Same cycle on an empty buffer -> `underflow` = 1, `count` = 1, next read gives 12.
